// File: rtl/wb_sram_writer.sv
// wb_sram_writer
// Wishbone slave that owns port 0 (read/write) of the two 2 KB SRAM macros
// holding pattern/waveform memory. Firmware loads and reads back the memories
// through this block. The wfg block reads the same macros on port 1, and there
// is no arbitration against it.
//
// Ports:
//   io_wbs_clk, io_wbs_rst_n   bus clock (also SRAM clk0), async active-low reset
//   io_wbs_adr/datwr/we/sel    request; word address bit MEM_AW selects the macro
//   io_wbs_stb/cyc             request qualifiers
//   io_wbs_datrd, io_wbs_ack   read data (held until the next read), 1-cycle ack
//   csb0/web0/wmask0/addr0/din0_mem{0,1}   SRAM port 0 command, all registered
//   dout0_mem{0,1}             SRAM port 0 read data
//
// state | meaning
// IDLE  | waiting for cyc & stb; on start drives one macro's command
// CMD   | SRAM captures the command this edge; command lines released
// RWAIT | counting READ_LAT edges before dout0 is sampled
// ACK   | ack high for one cycle (unless aborted), then back to IDLE
module wb_sram_writer #(
  parameter int unsigned MEM_AW   = 9,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              io_wbs_clk,
  input  logic              io_wbs_rst_n,
  input  logic [31:0]       io_wbs_adr,
  input  logic [31:0]       io_wbs_datwr,
  output logic [31:0]       io_wbs_datrd,
  input  logic              io_wbs_we,
  input  logic [3:0]        io_wbs_sel,
  input  logic              io_wbs_stb,
  input  logic              io_wbs_cyc,
  output logic              io_wbs_ack,
  output logic              csb0_mem0,
  output logic              csb0_mem1,
  output logic              web0_mem0,
  output logic              web0_mem1,
  output logic [3:0]        wmask0_mem0,
  output logic [3:0]        wmask0_mem1,
  output logic [MEM_AW-1:0] addr0_mem0,
  output logic [MEM_AW-1:0] addr0_mem1,
  output logic [31:0]       din0_mem0,
  output logic [31:0]       din0_mem1,
  input  logic [31:0]       dout0_mem0,
  input  logic [31:0]       dout0_mem1
);

  typedef enum logic [1:0] {IDLE, CMD, RWAIT, ACK} state_t;

  state_t                     state_q;
  logic [1:0]                 cnt_q;
  logic                       we_q;
  logic                       bank_q;
  logic                       ack_q;
  logic [31:0]                datrd_q;
  logic [1:0]                 csb0_q;
  logic [1:0]                 web0_q;
  logic [1:0][3:0]            wmask0_q;
  logic [1:0][MEM_AW-1:0]     addr0_q;
  logic [1:0][31:0]           din0_q;

  logic                       adr_bank;
  logic [MEM_AW-1:0]          adr_word;
  logic                       unused_adr;

  assign adr_bank = io_wbs_adr[MEM_AW+2];
  assign adr_word = io_wbs_adr[MEM_AW+1:2];
  // Range decode is done upstream in wb_mux; the byte offset is meaningless here.
  assign unused_adr = ^{io_wbs_adr[31:MEM_AW+3], io_wbs_adr[1:0]};

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      bank_q   <= 1'b0;
      ack_q    <= 1'b0;
      datrd_q  <= '0;
      csb0_q   <= 2'b11;
      web0_q   <= 2'b11;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_wbs_cyc && io_wbs_stb && !ack_q) begin
            // Request fields are latched only here; later changes are ignored.
            we_q                <= io_wbs_we;
            bank_q              <= adr_bank;
            csb0_q[adr_bank]    <= 1'b0;
            addr0_q[adr_bank]   <= adr_word;
            web0_q[adr_bank]    <= !io_wbs_we;
            if (io_wbs_we) begin
              wmask0_q[adr_bank] <= io_wbs_sel;
              din0_q[adr_bank]   <= io_wbs_datwr;
            end else begin
              wmask0_q[adr_bank] <= 4'h0;
            end
            state_q <= CMD;
          end
        end
        CMD: begin
          csb0_q <= 2'b11;
          web0_q <= 2'b11;
          if (we_q) begin
            // Dropping cyc aborts the ack only; the write is already in the SRAM.
            ack_q   <= io_wbs_cyc;
            state_q <= ACK;
          end else begin
            cnt_q   <= 2'(READ_LAT);
            state_q <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt_q <= 2'd1) begin
            datrd_q <= bank_q ? dout0_mem1 : dout0_mem0;
            ack_q   <= io_wbs_cyc;
            cnt_q   <= '0;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_wbs_ack   = ack_q;
  assign io_wbs_datrd = datrd_q;
  assign csb0_mem0    = csb0_q[0];
  assign csb0_mem1    = csb0_q[1];
  assign web0_mem0    = web0_q[0];
  assign web0_mem1    = web0_q[1];
  assign wmask0_mem0  = wmask0_q[0];
  assign wmask0_mem1  = wmask0_q[1];
  assign addr0_mem0   = addr0_q[0];
  assign addr0_mem1   = addr0_q[1];
  assign din0_mem0    = din0_q[0];
  assign din0_mem1    = din0_q[1];

endmodule

// File: tb/tb_wb_sram_writer.sv
// Bench for wb_sram_writer: dut1 uses READ_LAT=1, dut3 uses READ_LAT=3.
// Both share the bus except for strobe; each has its own pair of SRAM models.
// SRAM model index k = dut*2 + bank.
module tb_wb_sram_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] adr, datwr;
  logic        we, cyc, stb1, stb3;
  logic [3:0]  sel;
  logic [31:0] datrd1, datrd3;
  logic        ack1, ack3;

  logic [3:0]        csb, web;
  logic [3:0][3:0]   wmask;
  logic [3:0][8:0]   addr;
  logic [3:0][31:0]  din;
  logic [3:0][31:0]  dout = '0;

  wb_sram_writer #(.MEM_AW(9), .READ_LAT(1)) dut1 (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd1), .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb1),
    .io_wbs_cyc(cyc), .io_wbs_ack(ack1),
    .csb0_mem0(csb[0]), .csb0_mem1(csb[1]), .web0_mem0(web[0]), .web0_mem1(web[1]),
    .wmask0_mem0(wmask[0]), .wmask0_mem1(wmask[1]), .addr0_mem0(addr[0]), .addr0_mem1(addr[1]),
    .din0_mem0(din[0]), .din0_mem1(din[1]), .dout0_mem0(dout[0]), .dout0_mem1(dout[1]));

  wb_sram_writer #(.MEM_AW(9), .READ_LAT(3)) dut3 (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd3), .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb3),
    .io_wbs_cyc(cyc), .io_wbs_ack(ack3),
    .csb0_mem0(csb[2]), .csb0_mem1(csb[3]), .web0_mem0(web[2]), .web0_mem1(web[3]),
    .wmask0_mem0(wmask[2]), .wmask0_mem1(wmask[3]), .addr0_mem0(addr[2]), .addr0_mem1(addr[3]),
    .din0_mem0(din[2]), .din0_mem1(din[3]), .dout0_mem0(dout[2]), .dout0_mem1(dout[3]));

  // Synchronous SRAM models: command captured on the clock edge.
  logic [31:0] mem [4][512];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!csb[k]) begin
        if (!web[k]) begin
          for (int b = 0; b < 4; b++)
            if (wmask[k][b]) mem[k][addr[k]][8*b +: 8] = din[k][8*b +: 8];
        end else begin
          dout[k] <= mem[k][addr[k]];
        end
      end
    end
  end

  // Every cycle an SRAM is selected is logged as one access.
  typedef struct { int k; logic [8:0] a; logic web; logic [3:0] wm; logic [31:0] d; } rec_t;
  rec_t recs[$];
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!csb[k]) recs.push_back('{k, addr[k], web[k], wmask[k], din[k]});
  end

  // Reference memory for dut1, indexed by the 10-bit word address.
  logic [31:0] ref_mem [1024];

  function automatic void ref_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int idx;
    idx = int'((a >> 2) % 1024);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // One complete transaction; entered and left on a negedge with the DUT idle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input int which,
                      output int lat, output logic [31:0] rd, output logic [31:0] rd_after);
    recs.delete();
    adr = a; we = w; sel = s; datwr = d; cyc = 1'b1;
    if (which == 0) stb1 = 1'b1; else stb3 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((which == 0) ? ack1 : ack3) begin
        lat = n;
        break;
      end
    end
    rd = (which == 0) ? datrd1 : datrd3;
    cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0; we = 1'b0;
    @(negedge clk);
    rd_after = (which == 0) ? datrd1 : datrd3;
    if (which == 0 && w) ref_write(a, s, d);
  endtask

  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;
    int lat; int k; logic [8:0] word; logic [3:0] wm; logic [31:0] rd;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat, acks, t_last, extra, saw_ack;
    logic [31:0] rd, rd_after, last1;

    rst_n = 1'b0; adr = '0; datwr = '0; we = 1'b0; sel = 4'h0;
    cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0;
    for (int k = 0; k < 4; k++) for (int i = 0; i < 512; i++) mem[k][i] = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // rd column on writes is the value datrd must still hold.
    vt[0] = '{32'h0000_0014, 1'b1, 4'hF, 32'hDEADBEEF, 2, 0, 9'h005, 4'hF, 32'h0000_0000};
    vt[1] = '{32'h0000_0804, 1'b1, 4'h2, 32'h12345678, 2, 1, 9'h001, 4'h2, 32'h0000_0000};
    vt[2] = '{32'h0000_0014, 1'b0, 4'hF, 32'h0,        3, 0, 9'h005, 4'h0, 32'hDEADBEEF};
    vt[3] = '{32'h0000_0804, 1'b0, 4'hF, 32'h0,        3, 1, 9'h001, 4'h0, 32'h0000_5600};
    vt[4] = '{32'h0000_07FC, 1'b1, 4'h9, 32'hA5A5A5A5, 2, 0, 9'h1FF, 4'h9, 32'h0000_5600};
    vt[5] = '{32'hF000_0FFF, 1'b1, 4'hF, 32'h11223344, 2, 1, 9'h1FF, 4'hF, 32'h0000_5600};
    vt[6] = '{32'h0000_0016, 1'b1, 4'h0, 32'hCAFEF00D, 2, 0, 9'h005, 4'h0, 32'h0000_5600};
    vt[7] = '{32'h0000_0015, 1'b0, 4'hF, 32'h0,        3, 0, 9'h005, 4'h0, 32'hDEADBEEF};
    vt[8] = '{32'h0000_07FC, 1'b0, 4'hF, 32'h0,        3, 0, 9'h1FF, 4'h0, 32'hA50000A5};
    vt[9] = '{32'hF000_0FFF, 1'b0, 4'hF, 32'h0,        3, 1, 9'h1FF, 4'h0, 32'h11223344};

    // Reset values
    @(negedge clk);
    chk("rst_csb", 32'(csb), 32'hF);
    chk("rst_web", 32'(web), 32'hF);
    chk("rst_wmask", 32'(|wmask), 32'h0);
    chk("rst_addr", 32'(|addr), 32'h0);
    chk("rst_din", 32'(|din), 32'h0);
    chk("rst_datrd1", datrd1, 32'h0);
    chk("rst_datrd3", datrd3, 32'h0);
    chk("rst_ack", {30'h0, ack3, ack1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on dut1
    for (int i = 0; i < 10; i++) begin
      xfer(vt[i].adr, vt[i].we, vt[i].sel, vt[i].dat, 0, lat, rd, rd_after);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_nacc", i), 32'(recs.size()), 32'd1);
      if (recs.size() > 0) begin
        chk($sformatf("v%0d_bank", i), 32'(recs[0].k), 32'(vt[i].k));
        chk($sformatf("v%0d_addr", i), 32'(recs[0].a), 32'(vt[i].word));
        chk($sformatf("v%0d_web", i), 32'(recs[0].web), 32'(!vt[i].we));
        chk($sformatf("v%0d_wmask", i), 32'(recs[0].wm), 32'(vt[i].wm));
        if (vt[i].we) chk($sformatf("v%0d_din", i), recs[0].d, vt[i].dat);
      end
      chk($sformatf("v%0d_datrd", i), rd, vt[i].rd);
      chk($sformatf("v%0d_datrd_held", i), rd_after, vt[i].rd);
    end
    chk("mem1_word1_bytes", mem[1][1], 32'h0000_5600);
    last1 = 32'h11223344;

    // READ_LAT = 3 on dut3
    xfer(32'h14, 1'b1, 4'hF, 32'hDEADBEEF, 1, lat, rd, rd_after);
    chk("rl3_wr_lat", 32'(lat), 32'd2);
    xfer(32'h14, 1'b0, 4'hF, 32'h0, 1, lat, rd, rd_after);
    chk("rl3_rd_lat", 32'(lat), 32'd5);
    chk("rl3_rd_data", rd, 32'hDEADBEEF);
    chk("rl3_rd_held", rd_after, 32'hDEADBEEF);
    chk("rl3_nacc", 32'(recs.size()), 32'd1);
    if (recs.size() > 0) chk("rl3_bank", 32'(recs[0].k), 32'd2);

    // Back-to-back writes with stb held
    recs.delete();
    adr = 32'h0; datwr = 32'h1000_0000; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb1 = 1'b1;
    acks = 0; t_last = 0;
    for (int n = 1; n <= 40 && acks < 4; n++) begin
      @(negedge clk);
      if (ack1) begin
        acks++;
        ref_write(adr, 4'hF, datwr);
        if (acks == 4) begin
          cyc = 1'b0; stb1 = 1'b0; we = 1'b0; t_last = n;
        end else begin
          adr = adr + 32'd4; datwr = datwr + 32'd1;
        end
      end
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack1) extra++;
    end
    chk("b2b_acks", 32'(acks), 32'd4);
    chk("b2b_last_ack_cycle", 32'(t_last), 32'd11);
    chk("b2b_extra_ack", 32'(extra), 32'd0);
    chk("b2b_nacc", 32'(recs.size()), 32'd4);
    for (int i = 0; i < 4 && i < recs.size(); i++) begin
      chk($sformatf("b2b_addr%0d", i), 32'(recs[i].a), 32'(i));
      chk($sformatf("b2b_bank%0d", i), 32'(recs[i].k), 32'd0);
    end

    // Abort: cyc dropped while waiting for read data
    recs.delete();
    adr = 32'h804; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb1 = 1'b1; saw_ack = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack1) saw_ack++;
    end
    cyc = 1'b0; stb1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack1) saw_ack++;
    end
    chk("abort_no_ack", 32'(saw_ack), 32'd0);
    chk("abort_datrd_updated", datrd1, 32'h0000_5600);
    chk("abort_nacc", 32'(recs.size()), 32'd1);
    last1 = 32'h0000_5600;
    xfer(32'h20, 1'b1, 4'hF, 32'h5555AAAA, 0, lat, rd, rd_after);
    chk("abort_next_wr_lat", 32'(lat), 32'd2);
    chk("abort_next_wr_held", rd_after, last1);

    // Reset asserted while the read command is being captured
    adr = 32'h14; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb1 = 1'b1;
    @(negedge clk);
    chk("midrst_pre_csb", 32'(csb[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_csb", 32'(csb), 32'hF);
    chk("midrst_web", 32'(web), 32'hF);
    chk("midrst_ack", {30'h0, ack3, ack1}, 32'h0);
    chk("midrst_datrd1", datrd1, 32'h0);
    chk("midrst_datrd3", datrd3, 32'h0);
    cyc = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(32'h0, 1'b1, 4'hF, 32'h0BADC0DE, 0, lat, rd, rd_after);
    chk("postrst_wr_lat", 32'(lat), 32'd2);
    chk("postrst_datrd", rd, 32'h0);
    xfer(32'h0, 1'b0, 4'hF, 32'h0, 0, lat, rd, rd_after);
    chk("postrst_rd_lat", 32'(lat), 32'd3);
    chk("postrst_rd_data", rd, 32'h0BADC0DE);
    last1 = 32'h0BADC0DE;

    // Random traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      int unsigned r, bnk, wd, idx;
      logic [31:0] a, d, exp;
      logic w;
      logic [3:0] s;
      r   = $urandom();
      bnk = $urandom_range(0, 1);
      wd  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 511);
      a   = (r & 32'hFFFF_F003) | (bnk << 11) | (wd << 2);
      w   = ($urandom_range(0, 1) == 1);
      s   = 4'($urandom_range(0, 15));
      d   = $urandom();
      idx = bnk * 512 + wd;
      exp = w ? last1 : ref_mem[idx];
      xfer(a, w, s, d, 0, lat, rd, rd_after);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), w ? 32'd2 : 32'd3);
      chk($sformatf("rnd%0d_datrd", i), rd, exp);
      chk($sformatf("rnd%0d_datrd_held", i), rd_after, exp);
      chk($sformatf("rnd%0d_nacc", i), 32'(recs.size()), 32'd1);
      if (recs.size() > 0) begin
        chk($sformatf("rnd%0d_bank", i), 32'(recs[0].k), bnk);
        chk($sformatf("rnd%0d_addr", i), 32'(recs[0].a), wd);
        chk($sformatf("rnd%0d_wmask", i), 32'(recs[0].wm), w ? 32'(s) : 32'd0);
      end
      if (!w) last1 = exp;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
